// File: rtl/sim_pcie_axis_link_model.sv
// sim_pcie_axis_link_model: simulation stand-in for the PCIe endpoint user AXI-stream side.
// Sequences link-up, sources patterned RX packets per function and sinks/counts TX beats.
module sim_pcie_axis_link_model #(
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_FUNCS      = 2,
   parameter int SIZE_WIDTH     = 24,
   parameter int LINKUP_TIMEOUT = 16,
   parameter int ENABLE_DELAY   = 15
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [2:0]                      i_func_sel,
   input  logic [NUM_FUNCS*SIZE_WIDTH-1:0] i_func_sizes,
   input  logic [1:0]                      i_mode,
   input  logic [31:0]                     i_seed,
   input  logic                            i_rx_start,
   input  logic [3:0]                      i_tx_throttle,
   output logic                            o_lnk_up,
   output logic                            o_enable_comm,
   output logic                            o_rx_busy,
   output logic                            o_rx_done,
   output logic [DATA_WIDTH-1:0]           m_axis_rx_tdata,
   output logic [DATA_WIDTH/8-1:0]         m_axis_rx_tkeep,
   output logic                            m_axis_rx_tlast,
   output logic                            m_axis_rx_tvalid,
   input  logic                            m_axis_rx_tready,
   input  logic [DATA_WIDTH-1:0]           s_axis_tx_tdata,
   input  logic [DATA_WIDTH/8-1:0]         s_axis_tx_tkeep,
   input  logic                            s_axis_tx_tlast,
   input  logic                            s_axis_tx_tvalid,
   output logic                            s_axis_tx_tready,
   output logic [31:0]                     o_tx_beats,
   output logic [31:0]                     o_tx_pkts,
   output logic                            o_tx_keep_err
);
   localparam int LANES = DATA_WIDTH / 32;
   localparam int LSH   = $clog2(LANES);
   localparam int KW    = DATA_WIDTH / 8;

   typedef enum logic {S_IDLE, S_SEND} state_t;

   state_t                r_state, w_state_nxt;
   logic [31:0]           r_lnk_cnt, r_en_cnt;
   logic                  r_lnk_up, r_en;
   logic [SIZE_WIDTH-1:0] w_sizes [8];
   logic [SIZE_WIDTH-1:0] w_size, w_rem, w_nbeats;
   logic [SIZE_WIDTH-1:0] r_rem, r_nbeats, r_beat;
   logic [1:0]            r_mode;
   logic [31:0]           r_seed, r_base, r_lfsr;
   logic                  r_done;
   logic                  w_start, w_hs, w_last;
   logic [3:0]            r_thr;
   logic                  w_tx_hs, w_keep_bad;
   logic [31:0]           r_tx_beats, r_tx_pkts;
   logic                  r_keep_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lnk_cnt <= '0;
         r_lnk_up  <= 1'b0;
         r_en_cnt  <= '0;
         r_en      <= 1'b0;
      end else begin
         if (!r_lnk_up) begin
            r_lnk_cnt <= r_lnk_cnt + 32'd1;
            r_lnk_up  <= (r_lnk_cnt == 32'(LINKUP_TIMEOUT - 1));
         end
         if (r_lnk_up && r_en_cnt != 32'(ENABLE_DELAY)) r_en_cnt <= r_en_cnt + 32'd1;
         r_en <= r_lnk_up && (r_en_cnt == 32'(ENABLE_DELAY - 1));
      end
   end

   for (genvar f = 0; f < 8; f++) begin : g_size
      if (f < NUM_FUNCS) begin : g_on
         assign w_sizes[f] = i_func_sizes[f*SIZE_WIDTH +: SIZE_WIDTH];
      end else begin : g_off
         assign w_sizes[f] = '0;
      end
   end

   assign w_size   = w_sizes[i_func_sel];
   assign w_rem    = w_size & SIZE_WIDTH'(LANES - 1);
   assign w_nbeats = (w_size >> LSH) + SIZE_WIDTH'(w_rem != '0);
   assign w_start  = i_rx_start && r_lnk_up && r_state == S_IDLE;
   assign w_hs     = m_axis_rx_tvalid && m_axis_rx_tready;
   assign w_last   = r_beat == r_nbeats - SIZE_WIDTH'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state == S_IDLE ? ((w_start && w_size != '0) ? S_SEND : S_IDLE)
                                      : ((w_hs && w_last) ? S_IDLE : S_SEND);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_done   <= 1'b0;
         r_nbeats <= '0;
         r_rem    <= '0;
         r_beat   <= '0;
         r_mode   <= '0;
         r_seed   <= '0;
         r_base   <= '0;
         r_lfsr   <= '0;
      end else begin
         r_done <= (w_start && w_size == '0) || (r_state == S_SEND && w_hs && w_last);
         if (w_start) begin
            r_nbeats <= w_nbeats;
            r_rem    <= w_rem;
            r_beat   <= '0;
            r_mode   <= i_mode;
            r_seed   <= i_seed;
            r_base   <= i_seed;
            r_lfsr   <= i_seed == '0 ? 32'd1 : i_seed;
         end else if (w_hs) begin
            r_beat <= r_beat + SIZE_WIDTH'(1);
            r_base <= r_base + 32'(LANES);
            r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h8020_0003 : 32'h0);
         end
      end
   end

   // lanes past the remainder on the final beat get no byte enables
   always_comb begin
      m_axis_rx_tvalid = r_state == S_SEND;
      m_axis_rx_tlast  = m_axis_rx_tvalid && w_last;
      m_axis_rx_tdata  = '0;
      m_axis_rx_tkeep  = '0;
      for (int k = 0; k < LANES; k++) begin
         m_axis_rx_tdata[32*k +: 32] = !m_axis_rx_tvalid ? 32'h0 :
                                       r_mode == 2'd1 ? r_seed :
                                       r_mode == 2'd2 ? r_lfsr ^ 32'(k) : r_base + 32'(k);
         m_axis_rx_tkeep[4*k +: 4]   = (m_axis_rx_tvalid && (!w_last || r_rem == '0 || SIZE_WIDTH'(k) < r_rem)) ? 4'hF : 4'h0;
      end
   end

   assign o_lnk_up      = r_lnk_up;
   assign o_enable_comm = r_en;
   assign o_rx_busy     = r_state == S_SEND;
   assign o_rx_done     = r_done;

   // tdata is observed for completeness only; it never affects the counts
   assign w_tx_hs    = s_axis_tx_tvalid && s_axis_tx_tready && (|{s_axis_tx_tdata, 1'b1});
   assign w_keep_bad = s_axis_tx_tlast ? ((s_axis_tx_tkeep & (s_axis_tx_tkeep + KW'(1))) != '0)
                                       : (s_axis_tx_tkeep != '1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_thr      <= '0;
         r_tx_beats <= '0;
         r_tx_pkts  <= '0;
         r_keep_err <= 1'b0;
      end else begin
         r_thr <= (!r_lnk_up || r_thr >= i_tx_throttle) ? 4'd0 : r_thr + 4'd1;
         if (w_tx_hs) begin
            r_tx_beats <= r_tx_beats + 32'd1;
            r_tx_pkts  <= r_tx_pkts + 32'(s_axis_tx_tlast);
            r_keep_err <= r_keep_err || w_keep_bad;
         end
      end
   end

   assign s_axis_tx_tready = r_lnk_up && r_thr == 4'd0;
   assign o_tx_beats       = r_tx_beats;
   assign o_tx_pkts        = r_tx_pkts;
   assign o_tx_keep_err    = r_keep_err;
endmodule

// File: tb/tb_sim_pcie_axis_link_model.sv
// tb_sim_pcie_axis_link_model: randomized scoreboard bench for sim_pcie_axis_link_model (64-bit, 2 functions).
module tb_sim_pcie_axis_link_model;
   localparam int DW = 64, NF = 2, SW = 24, KW = 8;

   logic clk = 1'b0, rst = 1'b1;
   logic [2:0] i_func_sel = '0;
   logic [NF*SW-1:0] i_func_sizes = '0;
   logic [1:0] i_mode = '0;
   logic [31:0] i_seed = '0;
   logic i_rx_start = 1'b0;
   logic [3:0] i_tx_throttle = '0;
   logic o_lnk_up, o_enable_comm, o_rx_busy, o_rx_done;
   logic [DW-1:0] m_tdata;
   logic [KW-1:0] m_tkeep;
   logic m_tlast, m_tvalid;
   logic m_tready = 1'b1;
   logic [DW-1:0] s_tdata = '0;
   logic [KW-1:0] s_tkeep = '0;
   logic s_tlast = 1'b0, s_tvalid = 1'b0;
   logic s_tready;
   logic [31:0] o_tx_beats, o_tx_pkts;
   logic o_tx_keep_err;

   always #5 clk = ~clk;

   sim_pcie_axis_link_model #(.DATA_WIDTH(DW), .NUM_FUNCS(NF), .SIZE_WIDTH(SW),
                              .LINKUP_TIMEOUT(16), .ENABLE_DELAY(15)) dut (
      .clk(clk), .rst(rst), .i_func_sel(i_func_sel), .i_func_sizes(i_func_sizes),
      .i_mode(i_mode), .i_seed(i_seed), .i_rx_start(i_rx_start), .i_tx_throttle(i_tx_throttle),
      .o_lnk_up(o_lnk_up), .o_enable_comm(o_enable_comm), .o_rx_busy(o_rx_busy), .o_rx_done(o_rx_done),
      .m_axis_rx_tdata(m_tdata), .m_axis_rx_tkeep(m_tkeep), .m_axis_rx_tlast(m_tlast),
      .m_axis_rx_tvalid(m_tvalid), .m_axis_rx_tready(m_tready),
      .s_axis_tx_tdata(s_tdata), .s_axis_tx_tkeep(s_tkeep), .s_axis_tx_tlast(s_tlast),
      .s_axis_tx_tvalid(s_tvalid), .s_axis_tx_tready(s_tready),
      .o_tx_beats(o_tx_beats), .o_tx_pkts(o_tx_pkts), .o_tx_keep_err(o_tx_keep_err));

   typedef struct {logic [63:0] d; logic [7:0] k; logic l;} beat_t;
   beat_t rx_q[$];
   int checks = 0, errors = 0, zero_exp = 0, vcyc = 0;
   bit pend_done = 0;

   task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   // reference: dword i of the packet lives in beat i/2, lane i%2
   task automatic model_pkt(input int s, input int mode, input logic [31:0] seed);
      logic [31:0] st;
      int nb;
      st = seed == 0 ? 32'd1 : seed;
      nb = (s + 1) / 2;
      for (int b = 0; b < nb; b++) begin
         beat_t e;
         e.d = '0;
         e.k = '0;
         for (int k = 0; k < 2; k++) begin
            int i;
            i = b * 2 + k;
            if (i < s) begin
               e.k[4*k +: 4] = 4'hF;
               e.d[32*k +: 32] = mode == 1 ? seed : mode == 2 ? (st ^ 32'(k)) : seed + 32'(i);
            end
         end
         e.l = (b == nb - 1);
         rx_q.push_back(e);
         st = lfsr_step(st);
      end
   endtask

   // RX monitor / scoreboard
   logic [63:0] pd;
   logic [7:0] pk;
   logic pl;
   bit pstall = 0;
   always @(negedge clk) begin
      beat_t e;
      logic [63:0] m;
      if (pend_done) begin
         chk(o_rx_done, "rx_done_after_last", 64'(o_rx_done), 64'd1);
         pend_done = 0;
      end else if (o_rx_done) begin
         chk(zero_exp > 0, "rx_done_unexpected", 64'd1, 64'(zero_exp));
         if (zero_exp > 0) zero_exp--;
      end
      if (m_tvalid) begin
         vcyc++;
         if (pstall) chk({m_tdata, m_tkeep, m_tlast} == {pd, pk, pl}, "rx_stall_stable", m_tdata, pd);
         if (m_tready) begin
            if (rx_q.size() == 0) chk(1'b0, "rx_unexpected_beat", m_tdata, 64'd0);
            else begin
               e = rx_q.pop_front();
               for (int j = 0; j < 8; j++) m[8*j +: 8] = {8{e.k[j]}};
               chk((m_tdata & m) == e.d && m_tkeep == e.k && m_tlast == e.l, "rx_beat",
                   {m_tdata[59:0], m_tkeep[2:0], m_tlast}, {e.d[59:0], e.k[2:0], e.l});
               if (e.l) pend_done = 1;
            end
         end
         pstall = !m_tready;
         pd = m_tdata;
         pk = m_tkeep;
         pl = m_tlast;
      end else pstall = 0;
   end

   // TX ready-duty monitor
   int cyc = 0, last_rdy = -1;
   bit gap_chk = 0;
   always @(negedge clk) begin
      cyc++;
      if (s_tready) begin
         if (gap_chk && last_rdy >= 0)
            chk(cyc - last_rdy == int'(i_tx_throttle) + 1, "tx_ready_gap", 64'(cyc - last_rdy), 64'(int'(i_tx_throttle) + 1));
         last_rdy = cyc;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input int rmode);
      m_tready = rmode == 0 ? 1'b1 : rmode == 1 ? ~m_tready : 1'($urandom_range(0, 1));
   endtask

   task automatic rx_pkt(input int sel, input logic [23:0] sz0, input logic [23:0] sz1, input int mode,
                         input logic [31:0] seed, input int rmode, input bit dup);
      int s, c;
      s = sel == 0 ? int'(sz0) : sel == 1 ? int'(sz1) : 0;
      c = 0;
      i_func_sel = 3'(sel);
      i_func_sizes = {sz1, sz0};
      i_mode = 2'(mode);
      i_seed = seed;
      i_rx_start = 1'b1;
      m_tready = rmode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s > 0) model_pkt(s, mode == 3 ? 0 : mode, seed);
      else zero_exp++;
      tick;
      i_rx_start = 1'b0;
      upd(rmode);
      while ((o_rx_busy || rx_q.size() > 0) && c < 300) begin
         i_rx_start = dup && c == 1;
         tick;
         upd(rmode);
         c++;
      end
      i_rx_start = 1'b0;
      chk(c < 300, "rx_timeout", 64'(c), 64'd300);
      tick;
   endtask

   task automatic send_tx(input logic [7:0] keep, input logic last);
      int c;
      c = 0;
      s_tvalid = 1'b1;
      s_tdata = {$urandom, $urandom};
      s_tkeep = keep;
      s_tlast = last;
      while (c < 50) begin
         @(negedge clk);
         if (s_tready) break;
         c++;
      end
      if (c >= 50) chk(1'b0, "tx_ready_timeout", 64'(c), 64'd50);
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
   endtask

   initial begin
      int up_at, en_at, en_n, eb, ep, c;
      logic [7:0] kl;
      up_at = -1; en_at = -1; en_n = 0;
      tick;
      tick;
      chk({o_lnk_up, o_enable_comm, o_rx_busy, o_rx_done, m_tvalid, m_tlast, s_tready, o_tx_keep_err} == '0,
          "reset_ctrl", 64'({o_lnk_up, o_enable_comm, o_rx_busy, o_rx_done, m_tvalid, m_tlast, s_tready, o_tx_keep_err}), 64'd0);
      chk(m_tdata == '0 && m_tkeep == '0 && o_tx_beats == '0 && o_tx_pkts == '0, "reset_data",
          m_tdata | 64'(m_tkeep) | 64'(o_tx_beats) | 64'(o_tx_pkts), 64'd0);
      rst = 1'b0;
      vcyc = 0;
      // a start before link-up must be ignored
      for (int i = 1; i <= 40; i++) begin
         if (i == 5) begin
            i_func_sel = 3'd0;
            i_func_sizes = {24'd0, 24'd3};
            i_rx_start = 1'b1;
         end else i_rx_start = 1'b0;
         tick;
         if (o_lnk_up && up_at < 0) up_at = i;
         if (o_enable_comm) begin
            en_n++;
            en_at = i;
         end
      end
      chk(up_at == 16, "lnk_up_cycle", 64'(up_at), 64'd16);
      chk(en_at == 31 && en_n == 1, "enable_pulse", 64'(en_at), 64'd31);
      chk(o_lnk_up, "lnk_up_sticky", 64'(o_lnk_up), 64'd1);
      chk(vcyc == 0, "no_rx_before_link", 64'(vcyc), 64'd0);

      vcyc = 0;
      rx_pkt(0, 24'd5, 24'd0, 0, 32'h100, 0, 0);
      chk(vcyc == 3, "rx_valid_cycles_ready", 64'(vcyc), 64'd3);
      vcyc = 0;
      rx_pkt(0, 24'd5, 24'd0, 0, 32'h100, 1, 1);
      chk(vcyc == 6, "rx_valid_cycles_toggle", 64'(vcyc), 64'd6);
      vcyc = 0;
      rx_pkt(1, 24'd5, 24'd0, 0, 32'h100, 0, 0);
      rx_pkt(5, 24'd4, 24'd7, 2, 32'h1234, 0, 0);
      chk(vcyc == 0, "rx_size0_no_beats", 64'(vcyc), 64'd0);

      for (int i = 0; i < 30; i++)
         rx_pkt($urandom_range(0, 3), 24'($urandom_range(0, 9)), 24'($urandom_range(0, 9)), $urandom_range(0, 3),
                $urandom_range(0, 7) == 0 ? 32'd0 : $urandom, $urandom_range(0, 3) == 0 ? 0 : 2, 0);

      i_tx_throttle = 4'd3;
      tick;
      tick;
      last_rdy = -1;
      gap_chk = 1;
      for (int i = 0; i < 8; i++) send_tx(8'hFF, i == 3 || i == 7);
      gap_chk = 0;
      chk(o_tx_beats == 32'd8, "tx_beats", 64'(o_tx_beats), 64'd8);
      chk(o_tx_pkts == 32'd2, "tx_pkts", 64'(o_tx_pkts), 64'd2);
      chk(!o_tx_keep_err, "tx_no_err", 64'(o_tx_keep_err), 64'd0);

      eb = 8; ep = 2;
      i_tx_throttle = 4'($urandom_range(0, 5));
      for (int i = 0; i < 20; i++) begin
         logic l;
         l = 1'($urandom_range(0, 1));
         kl = 8'hFF >> $urandom_range(0, 7);
         send_tx(l ? kl : 8'hFF, l);
         eb++;
         ep += int'(l);
      end
      chk(o_tx_beats == 32'(eb), "tx_beats_rand", 64'(o_tx_beats), 64'(eb));
      chk(o_tx_pkts == 32'(ep), "tx_pkts_rand", 64'(o_tx_pkts), 64'(ep));
      chk(!o_tx_keep_err, "tx_no_err_rand", 64'(o_tx_keep_err), 64'd0);
      send_tx(8'h05, 1'b1);
      chk(o_tx_keep_err, "tx_keep_err", 64'(o_tx_keep_err), 64'd1);
      chk(o_tx_beats == 32'(eb + 1) && o_tx_pkts == 32'(ep + 1), "tx_count_err_beat", 64'(o_tx_beats), 64'(eb + 1));

      // stall a long packet, then reset in the middle of it
      m_tready = 1'b0;
      i_func_sel = 3'd0;
      i_func_sizes = {24'd0, 24'd20};
      i_mode = 2'd0;
      i_rx_start = 1'b1;
      tick;
      i_rx_start = 1'b0;
      tick;
      tick;
      chk(o_rx_busy && m_tvalid, "rx_stalled_busy", 64'({o_rx_busy, m_tvalid}), 64'd3);
      #3 rst = 1'b1;
      #1;
      chk(!m_tvalid, "rst_async_tvalid", 64'(m_tvalid), 64'd0);
      chk({o_lnk_up, o_rx_busy, o_tx_keep_err, s_tready} == '0 && o_tx_beats == '0 && o_tx_pkts == '0,
          "rst_clears", 64'({o_lnk_up, o_rx_busy, o_tx_keep_err, s_tready}) | 64'(o_tx_beats), 64'd0);
      tick;
      rst = 1'b0;
      c = 0;
      while (!o_lnk_up && c < 100) begin
         tick;
         c++;
      end
      chk(o_lnk_up, "relink", 64'(o_lnk_up), 64'd1);
      rx_pkt(1, 24'd3, 24'd9, 2, 32'd0, 2, 0);
      rx_pkt(0, 24'd7, 24'd2, 1, 32'hCAFEF00D, 2, 0);

      chk(rx_q.size() == 0 && zero_exp == 0, "scoreboard_drained", 64'(rx_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
